// File: rtl/fetch_queue_if.sv
// fetch_queue_if: handshake bundle between the fetch queue, the instruction
// cache, the Decoder and the RoB flush sources.
//   master : fetch_queue side (drives icache_req/addr, dec_*, count)
//   slave  : environment side (drives rdy, flushes, cache response, dec_accept)
interface fetch_queue_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic          rdy;
  logic          rob_clear;
  logic [31:0]   back_pc;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          icache_req;
  logic [31:0]   icache_addr;
  logic          icache_valid;
  logic [31:0]   icache_instr;
  logic          dec_valid;
  logic [31:0]   dec_instr;
  logic [31:0]   dec_addr;
  logic          dec_accept;
  logic [CW-1:0] count;

  modport master (
    input  rdy, rob_clear, back_pc, redirect, redirect_pc,
    input  icache_valid, icache_instr, dec_accept,
    output icache_req, icache_addr, dec_valid, dec_instr, dec_addr, count
  );

  modport slave (
    output rdy, rob_clear, back_pc, redirect, redirect_pc,
    output icache_valid, icache_instr, dec_accept,
    input  icache_req, icache_addr, dec_valid, dec_instr, dec_addr, count
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction prefetch buffer between the I-cache and
// the Decoder. Keeps a DEPTH-entry FIFO of {addr, instr} filled by one
// outstanding cache request at a time; flushes on RoB clear or Decoder
// redirect and discards any cache response that was in flight at the flush.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fetch_queue_if.master (rdy, flushes, icache req/resp,
//              decoder head/accept, occupancy count)
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.master bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_e;

  state_e        state_q;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_addr_q;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   addr_mem_q  [DEPTH];

  logic          flush_c;
  logic          push_c;
  logic          pop_c;
  logic [31:0]   target_c;

  // Qualified events; everything is masked while rdy is low.
  always_comb begin
    flush_c  = bus.rdy & (bus.rob_clear | bus.redirect);
    target_c = bus.rob_clear ? bus.back_pc : bus.redirect_pc;
    push_c   = bus.rdy & (state_q == WAIT) & bus.icache_valid & ~flush_c;
    pop_c    = bus.rdy & bus.dec_accept & (count_q != '0) & ~flush_c;
  end

  // FIFO bookkeeping and fetch address.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (flush_c) begin
      fetch_pc_d = target_c;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      if (push_c) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        tail_d     = tail_q + PW'(1);
      end
      if (pop_c) begin
        head_d = head_q + PW'(1);
      end
      if (push_c && !pop_c) begin
        count_d = count_q + CW'(1);
      end else if (pop_c && !push_c) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  // State, request address and storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        instr_mem_q[i] <= '0;
        addr_mem_q[i]  <= '0;
      end
    end else if (bus.rdy) begin
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      if (push_c) begin
        instr_mem_q[tail_q] <= bus.icache_instr;
        addr_mem_q[tail_q]  <= fetch_pc_q;
      end
      case (state_q)
        IDLE: begin
          // A response strobe here is a protocol violation and is ignored.
          if (flush_c) begin
            req_addr_q <= target_c;
            state_q    <= WAIT;
          end else if (count_q < DEPTH_C) begin
            req_addr_q <= fetch_pc_q;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          if (bus.icache_valid) begin
            if (flush_c) begin
              req_addr_q <= target_c;
            end else if (count_d < DEPTH_C) begin
              req_addr_q <= fetch_pc_d;
            end else begin
              state_q <= IDLE;
            end
          end else if (flush_c) begin
            // Old request stays on the bus until its stale response returns.
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (bus.icache_valid) begin
            req_addr_q <= flush_c ? target_c : fetch_pc_q;
            state_q    <= WAIT;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.icache_req  = (state_q != IDLE);
  assign bus.icache_addr = req_addr_q;
  assign bus.dec_valid   = (count_q != '0);
  assign bus.dec_instr   = instr_mem_q[head_q];
  assign bus.dec_addr    = addr_mem_q[head_q];
  assign bus.count       = count_q;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue with a latency-programmable
// I-cache model and a scoreboard of expected decoder entries.
module tb_fetch_queue;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
  } entry_t;

  entry_t      sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_pops   = 0;
  int          p0;
  logic        pend;
  logic        stale;
  int          cnt;
  int          lat;
  logic [31:0] paddr;
  logic [31:0] exp_req;
  logic        accept_en;

  function automatic logic [31:0] f(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend    = 1'b0;
    stale   = 1'b0;
    cnt     = 0;
    exp_req = 32'h0;
    sb.delete();
  endtask

  // One clock: drive cache/decoder from the outputs seen at this negedge,
  // then advance to the next negedge.
  task automatic cycle();
    logic   fl;
    entry_t e;
    fl = bus.rdy & (bus.rob_clear | bus.redirect);
    bus.icache_valid = 1'b0;
    bus.icache_instr = 32'h0;
    bus.dec_accept   = 1'b0;
    if (!bus.rdy) begin
      bus.icache_valid = 1'b1;
      bus.icache_instr = 32'hDEAD_BEEF;
      bus.dec_accept   = 1'b1;
    end else if (!rst) begin
      if (pend) begin
        chk("req_held", 32'(bus.icache_req), 32'd1);
        chk("req_addr_stable", bus.icache_addr, paddr);
        if (cnt <= 1) begin
          pend = 1'b0;
          bus.icache_valid = 1'b1;
          bus.icache_instr = f(paddr);
          if (!fl && !stale) begin
            e.addr  = paddr;
            e.instr = f(paddr);
            sb.push_back(e);
          end
          stale = 1'b0;
        end else begin
          cnt--;
        end
      end else if (bus.icache_req) begin
        chk("req_addr", bus.icache_addr, exp_req);
        paddr   = bus.icache_addr;
        exp_req = bus.icache_addr + 32'd4;
        pend    = 1'b1;
        cnt     = lat;
      end
      if (fl) begin
        sb.delete();
        if (pend) stale = 1'b1;
        exp_req = bus.rob_clear ? bus.back_pc : bus.redirect_pc;
      end
      if (accept_en && bus.dec_valid && !fl) begin
        bus.dec_accept = 1'b1;
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("dec_addr", bus.dec_addr, e.addr);
          chk("dec_instr", bus.dec_instr, e.instr);
          n_pops++;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_count(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (int'(bus.count) == target) break;
      cycle();
    end
    chk("wait_count", 32'(bus.count), 32'(target));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_icache_req"},  32'(bus.icache_req), 32'd0);
    chk({tag, "_icache_addr"}, bus.icache_addr,     32'h0);
    chk({tag, "_dec_valid"},   32'(bus.dec_valid),  32'd0);
    chk({tag, "_dec_instr"},   bus.dec_instr,       32'h0);
    chk({tag, "_dec_addr"},    bus.dec_addr,        32'h0);
    chk({tag, "_count"},       32'(bus.count),      32'd0);
  endtask

  initial begin
    bus.rdy          = 1'b1;
    bus.rob_clear    = 1'b0;
    bus.back_pc      = 32'h0;
    bus.redirect     = 1'b0;
    bus.redirect_pc  = 32'h0;
    bus.icache_valid = 1'b0;
    bus.icache_instr = 32'h0;
    bus.dec_accept   = 1'b0;
    accept_en        = 1'b0;
    lat              = 2;
    model_reset();

    // Reset state and first request.
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    rst = 1'b0;
    cycle();
    chk("first_req", 32'(bus.icache_req), 32'd1);
    chk("first_addr", bus.icache_addr, 32'h0);

    // Fill to DEPTH with no decoder accepts; requests must stop.
    wait_count(4, 40);
    repeat (4) cycle();
    chk("full_count", 32'(bus.count), 32'd4);
    chk("full_no_req", 32'(bus.icache_req), 32'd0);
    chk("full_head_addr", bus.dec_addr, 32'h0);
    chk("full_sb_size", 32'(sb.size()), 32'd4);

    // One pop: count drops, request resumes one edge later at 0x10.
    accept_en = 1'b1;
    cycle();
    accept_en = 1'b0;
    chk("pop_count", 32'(bus.count), 32'd3);
    chk("pop_no_req_yet", 32'(bus.icache_req), 32'd0);
    cycle();
    chk("resume_req", 32'(bus.icache_req), 32'd1);
    chk("resume_addr", bus.icache_addr, 32'h10);

    // rob_clear with a response pending three cycles out.
    lat = 3;
    bus.rob_clear = 1'b1;
    bus.back_pc   = 32'h100;
    cycle();
    bus.rob_clear = 1'b0;
    chk("flush_count", 32'(bus.count), 32'd0);
    chk("flush_dec_valid", 32'(bus.dec_valid), 32'd0);
    chk("drain_req", 32'(bus.icache_req), 32'd1);
    chk("drain_addr", bus.icache_addr, 32'h10);
    repeat (3) cycle();
    chk("stale_dropped", 32'(bus.count), 32'd0);
    chk("restart_addr", bus.icache_addr, 32'h100);
    p0 = n_pops;
    accept_en = 1'b1;
    repeat (14) cycle();
    chk("post_flush_pops", 32'(n_pops > p0), 32'd1);

    // rob_clear and redirect together: rob_clear wins.
    lat = 1;
    accept_en = 1'b0;
    bus.rob_clear   = 1'b1;
    bus.back_pc     = 32'h200;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h300;
    cycle();
    bus.rob_clear = 1'b0;
    bus.redirect  = 1'b0;
    chk("dual_count", 32'(bus.count), 32'd0);
    p0 = n_pops;
    accept_en = 1'b1;
    repeat (10) cycle();
    chk("dual_pops", 32'(n_pops > p0), 32'd1);

    // rdy low for 5 cycles with strobes on every input: nothing moves.
    accept_en = 1'b0;
    repeat (2) cycle();
    bus.rdy = 1'b0;
    repeat (5) cycle();
    chk("hold_count", 32'(bus.count), 32'(sb.size()));
    chk("hold_req", 32'(bus.icache_req), 32'd1);
    chk("hold_req_addr", bus.icache_addr, pend ? paddr : exp_req);
    if (sb.size() != 0) chk("hold_dec_addr", bus.dec_addr, sb[0].addr);
    bus.rdy = 1'b1;
    p0 = n_pops;
    accept_en = 1'b1;
    repeat (12) cycle();
    chk("rdy_resume_pops", 32'(n_pops > p0), 32'd1);

    // Async reset in WAIT with two entries buffered.
    accept_en = 1'b0;
    lat = 2;
    bus.rob_clear = 1'b1;
    bus.back_pc   = 32'h400;
    cycle();
    bus.rob_clear = 1'b0;
    wait_count(2, 40);
    chk("pre_rst_req", 32'(bus.icache_req), 32'd1);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    // Stale response strobe in IDLE on the release cycle must be ignored.
    rst = 1'b0;
    bus.icache_valid = 1'b1;
    bus.icache_instr = 32'hBAD0_BAD0;
    @(posedge clk);
    @(negedge clk);
    bus.icache_valid = 1'b0;
    chk("stale_idle_count", 32'(bus.count), 32'd0);
    chk("restart_req", 32'(bus.icache_req), 32'd1);
    chk("restart_rst_pc", bus.icache_addr, 32'h0);
    p0 = n_pops;
    accept_en = 1'b1;
    repeat (16) cycle();
    chk("post_rst_pops", 32'(n_pops > p0), 32'd1);
    accept_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
